// File: rtl/pulse_arb_pkg.sv
// pulse_arb_pkg
//   Shared types and helpers for the pulse window arbiter.
//   - pa_state_t : window sequencer states. GUARD exists only when
//                  PULSE_ARB_GUARD_EN is defined.
//   - PA_MAX_N   : widest requester vector rr_pick accepts.
//   - rr_pick    : round-robin one-hot winner search.
package pulse_arb_pkg;

  localparam int unsigned PA_MAX_N = 32;

`ifdef PULSE_ARB_GUARD_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GUARD  = 2'd2
  } pa_state_t;
`else
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pa_state_t;
`endif

  // Returns a one-hot vector with the first set bit of req found by searching
  // upward from ptr and wrapping modulo n. Returns all zero when req has no
  // bit set below n. ptr must be less than n.
  function automatic logic [PA_MAX_N-1:0] rr_pick(
    input logic [PA_MAX_N-1:0] req,
    input int unsigned         ptr,
    input int unsigned         n
  );
    logic [PA_MAX_N-1:0] one_hot;
    int unsigned         idx;
    logic                found;
    one_hot = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < PA_MAX_N; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx]) begin
          one_hot[idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
    return one_hot;
  endfunction

endpackage

// File: rtl/pulse_window_gen.sv
// pulse_window_gen
//   Moore counter FSM that sequences one fixed-length high window per start.
//   Optional feature macro: PULSE_ARB_GUARD_EN adds a one-cycle GUARD state
//   after each window.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   start in  begin a window (honoured only while idle)
//   y     out high for HIGH_CYCLES cycles per window (registered)
//   done  out high in the last high cycle of a window (registered)
//   busy  out equal to y
//   ready out high while idle and able to accept start (registered)
module pulse_window_gen
  import pulse_arb_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic y,
  output logic done,
  output logic busy,
  output logic ready
);

  localparam int unsigned     CW       = $clog2(HIGH_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(HIGH_CYCLES - 1);

  pa_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      y     <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Outputs are flops loaded from the next-state decode so they line up
      // with the state they describe.
      y     <= (state_nxt == ACTIVE);
      done  <= (state_nxt == ACTIVE) && (cnt_nxt == '0);
      ready <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACTIVE;
          cnt_nxt   = CNT_LOAD;
        end
      end
      ACTIVE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
`ifdef PULSE_ARB_GUARD_EN
          state_nxt = GUARD;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef PULSE_ARB_GUARD_EN
      GUARD: begin
        state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = y;

endmodule

// File: rtl/pulse_window_arbiter.sv
// pulse_window_arbiter
//   Round-robin arbiter sharing one timed pulse output among N requesters.
//   Each grant drives y high for HIGH_CYCLES cycles followed by a low gap.
//   Optional feature macro: PULSE_ARB_GUARD_EN (one extra low guard cycle
//   between windows).
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   req  in  [N] level request per requester (sampled only while idle)
//   gnt  out [N] one-hot window owner, zero outside a window
//   y    out shared pulse output
//   done out high in the last high cycle of a window
//   busy out high while a window is active (equal to y)
module pulse_window_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned HIGH_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         y,
  output logic         done,
  output logic         busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]       ptr, ptr_nxt, win_idx;
  logic [PA_MAX_N-1:0] pick_w;
  logic [N-1:0]        pick;
  logic                any_pick;
  logic                ready;
  logic                start;

  always_comb begin
    pick_w   = rr_pick(PA_MAX_N'(req), 32'(ptr), N);
    pick     = pick_w[N-1:0];
    any_pick = |pick_w;
    win_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_w[i]) win_idx = PW'(i);
    end
    ptr_nxt = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
  end

  // Reset outranks a coincident request, so no window starts on a reset edge.
  assign start = ready && any_pick && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt <= '0;
      ptr <= '0;
    end else if (start) begin
      gnt <= pick;
      ptr <= ptr_nxt;
    end else if (done) begin
      // done marks the final high cycle; the owner clears with y.
      gnt <= '0;
    end
  end

  pulse_window_gen #(
    .HIGH_CYCLES(HIGH_CYCLES)
  ) u_gen (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .y    (y),
    .done (done),
    .busy (busy),
    .ready(ready)
  );

endmodule

// File: tb/tb_pulse_window_arbiter.sv
// tb_pulse_window_arbiter
//   Directed and randomized stimulus checked every cycle against a window
//   schedule model (window start cycle, owner, next free sampling cycle).
module tb_pulse_window_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned HC = 3;
`ifdef PULSE_ARB_GUARD_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 1;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         y;
  logic         done;
  logic         busy;

  int n_checks;
  int n_fail;

  // Reference schedule
  int cyc;
  int free_at;
  int win_start;
  int owner;
  bit win_valid;
  int ptr_m;

  pulse_window_arbiter #(
    .N          (N),
    .HIGH_CYCLES(HC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt),
    .y   (y),
    .done(done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Apply the inputs sampled at the edge that ends cycle cyc.
  task automatic model_edge(input logic r, input logic [N-1:0] q);
    int w;
    if (r) begin
      win_valid = 1'b0;
      ptr_m     = 0;
      free_at   = cyc + 1;
    end else if (cyc >= free_at && q != '0) begin
      w = -1;
      for (int i = 0; i < int'(N); i++) begin
        if (w < 0 && q[(ptr_m + i) % N]) w = (ptr_m + i) % N;
      end
      owner     = w;
      win_start = cyc + 1;
      win_valid = 1'b1;
      ptr_m     = (w + 1) % N;
      free_at   = cyc + HC + GAP;
    end
    cyc++;
  endtask

  task automatic step(input logic r, input logic [N-1:0] q);
    bit           in_win;
    logic [N-1:0] exp_gnt;
    rst = r;
    req = q;
    @(posedge clk);
    model_edge(r, q);
    #1;
    in_win  = win_valid && cyc >= win_start && cyc < win_start + int'(HC);
    exp_gnt = in_win ? (N'(1) << owner) : '0;
    check("gnt",  32'(gnt),  32'(exp_gnt));
    check("y",    32'(y),    32'(in_win));
    check("done", 32'(done), 32'(in_win && cyc == win_start + int'(HC) - 1));
    check("busy", 32'(busy), 32'(in_win));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    free_at   = 0;
    win_start = 0;
    owner     = 0;
    win_valid = 1'b0;
    ptr_m     = 0;
    rst       = 1'b1;
    req       = '1;

    // Reset held with all requesting, then release: first owner is 0.
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    for (int i = 0; i < 20; i++) step(1'b0, 4'b1111);

    // Single one-cycle request from idle.
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000);
    step(1'b0, 4'b0100);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000);

    // Request dropped during its own window.
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0010);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000);

    // Reset in the second high cycle of requester 2's window.
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1100);

    // Reset coinciding with a request from idle.
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000);
    step(1'b1, 4'b1000);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b1000);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), N'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
